// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite/VRAM geometry, blitter state and command types
package sprite_pkg;
    localparam int SPR_W = 20;
    localparam int SPR_H = 20;
    localparam int SPR_PIXELS = SPR_W * SPR_H;
    localparam int NUM_SPRITES = 128;
    localparam int SCR_W = 320;
    localparam int SCR_H = 240;
    localparam int VRAM_WORDS_PER_ROW = 80;
    localparam logic [7:0] TRANSP_IDX = 8'h00;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} blit_state_t;

    typedef struct packed {
        logic [6:0] sprite;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] pal_ofs;
    } blit_cmd_t;

    // sprite * 400 as 256 + 128 + 16 shifts
    function automatic logic [15:0] sprite_base(input logic [6:0] s);
        return ({9'b0, s} << 8) + ({9'b0, s} << 7) + ({9'b0, s} << 4);
    endfunction
endpackage

// File: rtl/vram_addr_gen.sv
// vram_addr_gen: maps a signed screen pixel to its VRAM word, byte lane and visibility
module vram_addr_gen
    import sprite_pkg::*;
(
    input  logic [10:0] SX,
    input  logic [10:0] SY,
    output logic [14:0] VRAM_ADDR,
    output logic [3:0]  VRAM_BYTEEN,
    output logic        ON_SCREEN
);
    logic [14:0] sy_w;

    assign sy_w = {7'b0, SY[7:0]};
    assign ON_SCREEN = !SX[10] && !SY[10] && SX[9:0] < 10'(SCR_W) && SY[9:0] < 10'(SCR_H);
    // row * 80 as 64 + 16
    assign VRAM_ADDR = (sy_w << 6) + (sy_w << 4) + {8'b0, SX[8:2]};
    assign VRAM_BYTEEN = 4'b0001 << SX[1:0];
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: streams a 20x20 sprite from sprite memory into back-buffer VRAM with clipping and transparency
module sprite_blitter (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [6:0]  CMD_SPRITE,
    input  logic [9:0]  CMD_X,
    input  logic [9:0]  CMD_Y,
    input  logic [7:0]  CMD_PAL_OFS,
    output logic [15:0] SPR_ADDR,
    input  logic [7:0]  SPR_DATA,
    output logic [14:0] VRAM_ADDR,
    output logic [31:0] VRAM_DATA,
    output logic [3:0]  VRAM_BYTEEN,
    output logic        VRAM_WREN,
    output logic        BUSY,
    output logic        DONE
);
    import sprite_pkg::*;

    blit_state_t state, state_nxt;
    blit_cmd_t   cmd;
    logic [15:0] base;
    logic [8:0]  p;
    logic [4:0]  col, row;
    logic        col_wrap, last, accept;
    logic        st_valid;
    logic [10:0] sx, sy;
    logic [14:0] addr;
    logic [3:0]  byteen;
    logic        on_screen, wr;
    logic [7:0]  idx;

    assign accept = CMD_VALID && CMD_READY;
    assign col_wrap = col == 5'(SPR_W - 1);
    assign last = p == 9'(SPR_PIXELS - 1);
    assign base = sprite_base(cmd.sprite);

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        CMD_READY = 1'b0;
        BUSY = 1'b1;
        DONE = 1'b0;
        case (state)
            IDLE: begin
                CMD_READY = 1'b1;
                BUSY = 1'b0;
                if (CMD_VALID) state_nxt = READ;
            end
            READ: if (last) state_nxt = DRAIN;
            DRAIN: state_nxt = sprite_pkg::DONE;
            default: begin
                CMD_READY = 1'b1;
                DONE = 1'b1;
                state_nxt = CMD_VALID ? READ : IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd <= '0;
            p <= '0;
            col <= '0;
            row <= '0;
            st_valid <= 1'b0;
            sx <= '0;
            sy <= '0;
        end else begin
            st_valid <= state == READ;
            sx <= {cmd.x[9], cmd.x} + {6'b0, col};
            sy <= {cmd.y[9], cmd.y} + {6'b0, row};
            if (accept) begin
                cmd <= {CMD_SPRITE, CMD_X, CMD_Y, CMD_PAL_OFS};
                p <= '0;
                col <= '0;
                row <= '0;
            end else if (state == READ) begin
                p <= p + 9'd1;
                col <= col_wrap ? 5'd0 : col + 5'd1;
                row <= row + {4'b0, col_wrap};
            end
        end
    end

    assign SPR_ADDR = state == READ ? base + {7'b0, p} : 16'd0;

    vram_addr_gen u_addr (
        .SX(sx),
        .SY(sy),
        .VRAM_ADDR(addr),
        .VRAM_BYTEEN(byteen),
        .ON_SCREEN(on_screen)
    );

    // write stage consumes the sprite byte read one cycle earlier
    assign idx = SPR_DATA + cmd.pal_ofs;
    assign wr = st_valid && SPR_DATA != TRANSP_IDX && on_screen;
    assign VRAM_WREN = wr;
    assign VRAM_ADDR = wr ? addr : 15'd0;
    assign VRAM_BYTEEN = wr ? byteen : 4'd0;
    assign VRAM_DATA = wr ? {4{idx}} : 32'd0;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench comparing every VRAM write, write count and DONE latency
module tb_sprite_blitter;
    logic        CLK = 0;
    logic        RESET_N;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [6:0]  CMD_SPRITE;
    logic [9:0]  CMD_X, CMD_Y;
    logic [7:0]  CMD_PAL_OFS;
    logic [15:0] SPR_ADDR;
    logic [7:0]  SPR_DATA;
    logic [14:0] VRAM_ADDR;
    logic [31:0] VRAM_DATA;
    logic [3:0]  VRAM_BYTEEN;
    logic        VRAM_WREN, BUSY, DONE;

    typedef struct packed {
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [11:0] off;
    } wr_t;

    logic [7:0] mem [0:51199];
    wr_t q[$];
    int cyc = 0, t0 = 0, prev_t0 = 0;
    int n_chk = 0, n_pass = 0;
    int n_wr = 0, total_wr = 0, last_nwr = 0, done_cnt = 0, acc_cnt = 0;
    logic [31:0] first_data;
    logic [14:0] first_addr;
    logic [3:0]  first_be;

    sprite_blitter dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_SPRITE(CMD_SPRITE), .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_PAL_OFS(CMD_PAL_OFS),
        .SPR_ADDR(SPR_ADDR), .SPR_DATA(SPR_DATA), .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA),
        .VRAM_BYTEEN(VRAM_BYTEEN), .VRAM_WREN(VRAM_WREN), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    always @(posedge CLK) SPR_DATA <= mem[SPR_ADDR];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_push(input int spr, input int x, input int y, input logic [7:0] pal);
        logic [7:0] d, v;
        int sx, sy;
        wr_t e;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) begin
                d = mem[spr * 400 + r * 20 + c];
                sx = x + c;
                sy = y + r;
                if (d != 8'h00 && sx >= 0 && sx < 320 && sy >= 0 && sy < 240) begin
                    v = d + pal;
                    e.a = 15'(sy * 80 + sx / 4);
                    e.be = 4'(1 << (sx % 4));
                    e.d = {4{v}};
                    e.off = 12'(2 + r * 20 + c);
                    q.push_back(e);
                end
            end
    endtask

    always @(negedge CLK) begin
        if (!RESET_N) q.delete();
        else begin
            if (VRAM_WREN) begin
                n_wr++;
                total_wr++;
                if (n_wr == 1) begin
                    first_data = VRAM_DATA;
                    first_addr = VRAM_ADDR;
                    first_be = VRAM_BYTEEN;
                end
                chk("write_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    wr_t e;
                    e = q.pop_front();
                    chk("write", {1'b0, VRAM_ADDR, VRAM_BYTEEN, VRAM_DATA, 12'(cyc - t0)}, {1'b0, e});
                end
            end
            if (DONE) begin
                done_cnt++;
                last_nwr = n_wr;
                chk("done_lat", 64'(cyc - t0), 64'd402);
                chk("leftover", 64'(q.size()), 64'd0);
            end
            if (CMD_VALID && CMD_READY) begin
                acc_cnt++;
                prev_t0 = t0;
                t0 = cyc;
                n_wr = 0;
                model_push(int'(CMD_SPRITE), int'($signed(CMD_X)), int'($signed(CMD_Y)), CMD_PAL_OFS);
            end
        end
    end

    task automatic send(input int spr, input int x, input int y, input logic [7:0] pal);
        int start = acc_cnt, n = 0;
        CMD_SPRITE = 7'(spr);
        CMD_X = 10'(x);
        CMD_Y = 10'(y);
        CMD_PAL_OFS = pal;
        CMD_VALID = 1;
        while (acc_cnt == start && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        #1 CMD_VALID = 0;
        chk("accepted", 64'(acc_cnt - start), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt, n = 0;
        while (done_cnt == start && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk(tag, 64'(done_cnt - start), 64'd1);
    endtask

    task automatic blit(input int spr, input int x, input int y, input logic [7:0] pal, input int exp_wr, input string tag);
        send(spr, x, y, pal);
        wait_done({tag, "_done"});
        chk({tag, "_count"}, 64'(last_nwr), 64'(exp_wr));
    endtask

    initial begin
        int done_before, wr_before;
        for (int i = 0; i < 51200; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 400; i++) begin
            mem[3 * 400 + i] = 8'h05;
            mem[5 * 400 + i] = ((i / 20 + i % 20) % 2) != 0 ? 8'h07 : 8'h00;
            mem[9 * 400 + i] = 8'hF0;
        end
        RESET_N = 0;
        CMD_VALID = 0;
        CMD_SPRITE = 0;
        CMD_X = 0;
        CMD_Y = 0;
        CMD_PAL_OFS = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ctl", {60'd0, CMD_READY, BUSY, DONE, VRAM_WREN}, 64'h8);
        chk("rst_addr", {29'd0, SPR_ADDR, VRAM_ADDR, VRAM_BYTEEN}, 64'd0);
        chk("rst_data", 64'(VRAM_DATA), 64'd0);
        RESET_N = 1;
        repeat (2) @(posedge CLK);
        #1;

        blit(3, 40, 20, 8'h00, 400, "s3");
        chk("s3_first_data", 64'(first_data), 64'h05050505);
        chk("s3_first_addr", {45'd0, first_addr, first_be}, {45'd0, 15'd1610, 4'b0001});
        blit(5, 0, 0, 8'h00, 200, "checker");
        blit(3, -5, 230, 8'h00, 150, "clip_lb");
        blit(3, 315, 100, 8'h00, 100, "clip_r");
        blit(3, 320, 0, 8'h00, 0, "offscreen");
        blit(9, 100, 50, 8'h20, 400, "pal");
        chk("pal_wrap", 64'(first_data), 64'h10101010);

        send(7, 200, 150, 8'h33);
        send(3, 10, 10, 8'h01);
        chk("b2b_gap", 64'(t0 - prev_t0), 64'd402);
        wait_done("b2b_done");
        chk("b2b_count", 64'(last_nwr), 64'd400);

        send(3, 0, 0, 8'h00);
        repeat (99) @(posedge CLK);
        #1;
        RESET_N = 0;
        #1;
        chk("rst_mid_cycle", 64'(cyc - t0), 64'd100);
        chk("rst_mid_ctl", {60'd0, CMD_READY, BUSY, DONE, VRAM_WREN}, 64'h8);
        chk("rst_mid_addr", {29'd0, SPR_ADDR, VRAM_ADDR, VRAM_BYTEEN}, 64'd0);
        chk("rst_mid_data", 64'(VRAM_DATA), 64'd0);
        done_before = done_cnt;
        wr_before = total_wr;
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1;
        #1;
        chk("post_rst_ready", {62'd0, CMD_READY, BUSY}, 64'h2);
        repeat (450) @(posedge CLK);
        #1;
        chk("post_rst_no_done", 64'(done_cnt - done_before), 64'd0);
        chk("post_rst_no_write", 64'(total_wr - wr_before), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
